// File: rtl/xbar_out_stage.sv
// rtl/xbar_out_stage.sv - crossbar output mux with 2-entry skid buffer; optional ONEHOT_CHECK_EN grant checker
module xbar_out_stage #(
    parameter int NPORT = 5,
    parameter int DATAW = 64,
    parameter int VCHW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT*DATAW-1:0] idata,
    input  logic [NPORT-1:0]       ivalid,
    input  logic [NPORT*VCHW-1:0]  ivch,
    input  logic [NPORT-1:0]       sel,
    output logic                   iready,
    output logic [DATAW-1:0]       odata,
    output logic                   ovalid,
    output logic [VCHW-1:0]        ovch,
    input  logic                   oready
`ifdef ONEHOT_CHECK_EN
    ,
    output logic                   sel_err
`endif
);

    logic [DATAW-1:0] cand_data;
    logic [VCHW-1:0]  cand_vch;
    logic             cand_any_valid;
    logic             sel_onehot;
    logic             cand_valid;
    logic             push;
    logic             pop;

    logic             main_valid_q, main_valid_d;
    logic [DATAW-1:0] main_data_q,  main_data_d;
    logic [VCHW-1:0]  main_vch_q,   main_vch_d;
    logic             skid_valid_q, skid_valid_d;
    logic [DATAW-1:0] skid_data_q,  skid_data_d;
    logic [VCHW-1:0]  skid_vch_q,   skid_vch_d;

    // AND-OR mux; only meaningful when sel is one-hot, which cand_valid enforces
    always_comb begin
        cand_data      = '0;
        cand_vch       = '0;
        cand_any_valid = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (sel[i]) begin
                cand_data      = cand_data | idata[i*DATAW +: DATAW];
                cand_vch       = cand_vch | ivch[i*VCHW +: VCHW];
                cand_any_valid = cand_any_valid | ivalid[i];
            end
        end
    end

    assign sel_onehot = (sel != '0) && ((sel & (sel - {{(NPORT-1){1'b0}}, 1'b1})) == '0);
    assign cand_valid = sel_onehot & cand_any_valid;
    assign iready     = ~skid_valid_q;
    assign push       = cand_valid & iready;
    assign pop        = main_valid_q & oready;

    // A push can only happen with the skid empty, so a skid refill never competes with a push
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_vch_d   = main_vch_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_vch_d   = skid_vch_q;
        if (pop || !main_valid_q) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_vch_d   = skid_vch_q;
                skid_valid_d = 1'b0;
            end else if (push) begin
                main_valid_d = 1'b1;
                main_data_d  = cand_data;
                main_vch_d   = cand_vch;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = cand_data;
            skid_vch_d   = cand_vch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_vch_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_vch_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_vch_q   <= main_vch_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_vch_q   <= skid_vch_d;
        end
    end

    assign ovalid = main_valid_q;
    assign odata  = main_data_q;
    assign ovch   = main_vch_q;

`ifdef ONEHOT_CHECK_EN
    logic sel_multi_hot;
    logic sel_err_q;

    // Zero sel is an idle cycle, not an error
    assign sel_multi_hot = (sel != '0) && !sel_onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (sel_multi_hot) begin
            sel_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!sel_multi_hot) else $error("xbar_out_stage: multi-hot sel %b", sel);
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_xbar_out_stage.sv
// tb/tb_xbar_out_stage.sv - randomized scoreboard bench for xbar_out_stage
module tb_xbar_out_stage;
    localparam int NPORT = 5;
    localparam int DATAW = 64;
    localparam int VCHW  = 2;
    localparam int FW    = DATAW + VCHW;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NPORT*DATAW-1:0] idata;
    logic [NPORT-1:0]       ivalid;
    logic [NPORT*VCHW-1:0]  ivch;
    logic [NPORT-1:0]       sel;
    logic                   iready;
    logic [DATAW-1:0]       odata;
    logic                   ovalid;
    logic [VCHW-1:0]        ovch;
    logic                   oready;
`ifdef ONEHOT_CHECK_EN
    logic                   sel_err;
`endif

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int n_out  = 0;
    logic [FW-1:0] exp_q[$];

    xbar_out_stage #(.NPORT(NPORT), .DATAW(DATAW), .VCHW(VCHW)) dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch), .sel(sel),
        .iready(iready), .odata(odata), .ovalid(ovalid), .ovch(ovch), .oready(oready)
`ifdef ONEHOT_CHECK_EN
        , .sel_err(sel_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the stage is a 2-deep FIFO that accepts whenever it holds fewer than two flits
    always @(negedge clk) begin
        int occ;
        logic [FW-1:0] f;
        if (rst) begin
            exp_q.delete();
        end else begin
            occ = exp_q.size();
            chk("ovalid", {63'd0, ovalid}, {63'd0, occ > 0});
            chk("iready", {63'd0, iready}, {63'd0, occ < 2});
            if (oready && occ > 0) begin
                f = exp_q.pop_front();
                chk("odata", odata, f[DATAW-1:0]);
                chk("ovch", {{(64-VCHW){1'b0}}, ovch}, {{(64-VCHW){1'b0}}, f[FW-1:DATAW]});
                n_out++;
            end
            if ($countones(sel) == 1 && occ < 2) begin
                for (int i = 0; i < NPORT; i++) begin
                    if (sel[i] && ivalid[i]) begin
                        exp_q.push_back({ivch[i*VCHW +: VCHW], idata[i*DATAW +: DATAW]});
                        n_acc++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [DATAW-1:0] d, input logic [VCHW-1:0] v);
        idata[p*DATAW +: DATAW] = d;
        ivch[p*VCHW +: VCHW]    = v;
    endtask

    task automatic drain(input string name);
        int n;
        oready = 1'b1;
        ivalid = '0;
        n = 0;
        while ((exp_q.size() > 0 || ovalid) && n < 20) begin
            step();
            n++;
        end
        chk({name, "_drained"}, {63'd0, ovalid}, 64'd0);
    endtask

    initial begin
        int start;
        int cyc;
        rst    = 1'b1;
        idata  = '0;
        ivalid = '0;
        ivch   = '0;
        sel    = '0;
        oready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_ovalid", {63'd0, ovalid}, 64'd0);
        chk("rst_iready", {63'd0, iready}, 64'd1);
        chk("rst_odata", odata, 64'd0);
        chk("rst_ovch", {62'd0, ovch}, 64'd0);
`ifdef ONEHOT_CHECK_EN
        chk("rst_sel_err", {63'd0, sel_err}, 64'd0);
`endif

        // Single flit through port 2
        step();
        sel    = 5'b00100;
        ivalid = 5'b00100;
        oready = 1'b1;
        set_port(2, 64'hA5, 2'd1);
        step();
        chk("t2_ovalid", {63'd0, ovalid}, 64'd1);
        chk("t2_odata", odata, 64'hA5);
        chk("t2_ovch", {62'd0, ovch}, 64'd1);
        ivalid = '0;
        drain("t2");

        // Backpressure: F0 main, F1 skid, F2 refused
        oready = 1'b0;
        sel    = 5'b00001;
        ivalid = '1;
        for (int k = 0; k < 3; k++) begin
            set_port(0, 64'hF000 + 64'(k), 2'(k));
            step();
        end
        chk("t3_iready_full", {63'd0, iready}, 64'd0);
        ivalid = '0;
        step();
        chk("t3_held_odata", odata, 64'hF000);
        drain("t3");

        // Zero and multi-hot grants never accept
        ivalid = '1;
        sel    = 5'b00000;
        step();
        step();
        sel = 5'b00110;
        step();
        step();
        chk("t4_ovalid", {63'd0, ovalid}, 64'd0);
`ifdef ONEHOT_CHECK_EN
        sel = 5'b00000;
        step();
        step();
        chk("t4_sel_err_sticky", {63'd0, sel_err}, 64'd1);
`endif
        sel    = '0;
        ivalid = '0;
        step();

        // Random streaming with rotating grant
        start = n_acc;
        cyc   = 0;
        while (n_acc - start < 100 && cyc < 3000) begin
            sel = NPORT'(1) << (cyc % NPORT);
            for (int p = 0; p < NPORT; p++)
                set_port(p, {$urandom, $urandom}, VCHW'($urandom));
            ivalid = NPORT'($urandom_range(0, 31) | $urandom_range(0, 31));
            oready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        chk("t5_accepted", 64'(n_acc - start >= 100), 64'd1);
        sel = '0;
        drain("t5");
        chk("t5_in_eq_out", 64'(n_acc), 64'(n_out));

        // Asynchronous reset while full
        oready = 1'b0;
        sel    = 5'b01000;
        ivalid = 5'b01000;
        set_port(3, 64'h1111, 2'd2);
        step();
        set_port(3, 64'h2222, 2'd3);
        step();
        ivalid = '0;
        chk("t6_full", {63'd0, iready}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ovalid", {63'd0, ovalid}, 64'd0);
        chk("t6_iready", {63'd0, iready}, 64'd1);
        chk("t6_odata", odata, 64'd0);
`ifdef ONEHOT_CHECK_EN
        chk("t6_sel_err", {63'd0, sel_err}, 64'd0);
`endif
        step();
        rst    = 1'b0;
        oready = 1'b1;
        step();
        step();
        chk("t6_no_output", {63'd0, ovalid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
